// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, default fetch
// stride and the word-alignment helper applied to redirect targets.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    REDIRECT
  } pc_state_e;

  localparam int unsigned INSTR_BYTES_DEFAULT = 4;
  localparam logic [31:0] ALIGN_MASK          = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_wait_timer.sv
// Fetch-wait watchdog: counts stalled fetch cycles and emits a one-cycle
// registered expiry pulse each time the count reaches MAX_WAIT.
module pc_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [7:0] count_q;
  logic       expire_q;

  // The count that would reach MAX_WAIT is replaced by the pulse and a restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (clear_i) begin
        count_q <= '0;
      end else if (inc_i) begin
        if (count_q == 8'(MAX_WAIT - 1)) begin
          count_q  <= '0;
          expire_q <= 1'b1;
        end else begin
          count_q <= count_q + 8'd1;
        end
      end
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and IF/ID/EX hazard control for the fetch stage.
// Optional fetch-wait timeout is built when PC_SEQ_TIMEOUT_EN is defined.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned INSTR_BYTES  = INSTR_BYTES_DEFAULT,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        if_ack,
  input  logic        load_use_hazard,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        if_req,
  output logic        PCWrite,
  output logic [31:0] PC_next,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        fetch_timeout
);

  if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("pc_sequencer: MAX_WAIT must be within 1..255");
  end

  pc_state_e   state_q;
  logic        pend_q;
  logic [31:0] pend_tgt_q;
  logic        if_req_q;
  logic        stall_q;
  logic        flush_ifid_q;
  logic        flush_idex_q;

  logic        fetching;
  logic        apply_redirect;
  logic        hazard_hold;
  logic        advance;
  logic [31:0] redirect_tgt;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    fetching       = (state_q == FETCH) || (state_q == WAIT);
    apply_redirect = fetching && if_ack && (ex_redirect || pend_q);
    hazard_hold    = fetching && !apply_redirect && load_use_hazard;
    advance        = fetching && if_ack && !ex_redirect && !pend_q && !load_use_hazard;
    redirect_tgt   = ex_redirect ? align_word(ex_target) : pend_tgt_q;
  end

  always_comb begin
    PCWrite = 1'b0;
    PC_next = pc_in;
    if (state_q == BOOT) begin
      PCWrite = 1'b1;
      PC_next = RESET_VECTOR;
    end else if (apply_redirect) begin
      PCWrite = 1'b1;
      PC_next = redirect_tgt;
    end else if (advance) begin
      PCWrite = 1'b1;
      PC_next = pc_in + 32'(INSTR_BYTES);
    end
  end

  // Control outputs are registered: they reflect the decision taken in the
  // previous cycle, so the redirect flushes are visible during REDIRECT.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      if_req_q     <= 1'b0;
      stall_q      <= 1'b0;
      flush_ifid_q <= 1'b0;
      flush_idex_q <= 1'b0;
    end else begin
      if_req_q     <= 1'b1;
      stall_q      <= fetching && !apply_redirect && (!if_ack || load_use_hazard);
      flush_ifid_q <= apply_redirect;
      flush_idex_q <= apply_redirect || hazard_hold;

      case (state_q)
        BOOT, REDIRECT: state_q <= FETCH;
        default: begin
          if (apply_redirect) state_q <= REDIRECT;
          else if (if_ack)    state_q <= FETCH;
          else                state_q <= WAIT;
        end
      endcase

      // A redirect that cannot be taken yet is parked; a newer one overwrites it.
      if (apply_redirect) begin
        pend_q <= 1'b0;
      end else if (ex_redirect && state_q != BOOT) begin
        pend_q     <= 1'b1;
        pend_tgt_q <= align_word(ex_target);
      end
    end
  end

  assign if_req     = if_req_q;
  assign stall_ifid = stall_q;
  assign flush_ifid = flush_ifid_q;
  assign flush_idex = flush_idex_q;

`ifdef PC_SEQ_TIMEOUT_EN
  logic timer_clear;
  logic timer_inc;

  assign timer_clear = (state_q != WAIT);
  assign timer_inc   = (state_q == WAIT) && !if_ack;

  pc_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .inc_i    (timer_inc),
    .expire_o (fetch_timeout)
  );
`else
  assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the rules.
module tb_pc_sequencer;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam int          MAXW = 15;
`ifdef PC_SEQ_TIMEOUT_EN
  localparam int EXP_PULSES = 1;
`else
  localparam int EXP_PULSES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        if_ack = 1'b0;
  logic        load_use_hazard = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic        if_req, PCWrite, stall_ifid, flush_ifid, flush_idex, fetch_timeout;
  logic [31:0] PC_next;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (4),
    .MAX_WAIT     (MAXW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .if_ack          (if_ack),
    .load_use_hazard (load_use_hazard),
    .ex_redirect     (ex_redirect),
    .ex_target       (ex_target),
    .if_req          (if_req),
    .PCWrite         (PCWrite),
    .PC_next         (PC_next),
    .stall_ifid      (stall_ifid),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .fetch_timeout   (fetch_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase flags, the PC register, a pending-redirect slot,
  // a wait-length count and the control outputs expected in the next cycle.
  bit          m_boot, m_redir, m_waiting, m_pend;
  int          m_wait_len;
  logic [31:0] m_pc, m_pend_tgt;
  bit          e_if_req, e_stall, e_fifid, e_fidex, e_tmo;

  bit          last_pcw, last_ifreq, last_stall, last_fifid, last_fidex, last_tmo;
  logic [31:0] last_next;
  int          tmo_seen, pulse_at;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_redir = 1'b0; m_waiting = 1'b0; m_pend = 1'b0;
    m_wait_len = 0; m_pend_tgt = '0;
    e_if_req = 1'b0; e_stall = 1'b0; e_fifid = 1'b0; e_fidex = 1'b0; e_tmo = 1'b0;
  endtask

  // Called just after a rising edge; rst is asserted asynchronously mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk1("rst_if_req", if_req, 1'b0);
    chk1("rst_stall", stall_ifid, 1'b0);
    chk1("rst_flush_ifid", flush_ifid, 1'b0);
    chk1("rst_flush_idex", flush_idex, 1'b0);
    chk1("rst_timeout", fetch_timeout, 1'b0);
    chk1("rst_pcwrite", PCWrite, 1'b1);
    chk32("rst_pc_next", PC_next, RV);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic step(input bit ack, input bit hz, input bit rd, input logic [31:0] tgt);
    bit          fetching, take_rd, adv, e_pcw;
    logic [31:0] e_next;
    if_ack = ack; load_use_hazard = hz; ex_redirect = rd; ex_target = tgt; pc_in = m_pc;
    fetching = !m_boot && !m_redir;
    take_rd  = fetching && ack && (rd || m_pend);
    adv      = fetching && ack && !rd && !m_pend && !hz;
    e_pcw    = m_boot || take_rd || adv;
    if (m_boot)       e_next = RV;
    else if (take_rd) e_next = (rd ? tgt : m_pend_tgt) & ~32'h3;
    else              e_next = m_pc + 32'd4;

    @(negedge clk);
    last_pcw = PCWrite; last_next = PC_next; last_ifreq = if_req; last_stall = stall_ifid;
    last_fifid = flush_ifid; last_fidex = flush_idex; last_tmo = fetch_timeout;
    if (fetch_timeout === 1'b1) tmo_seen++;
    chk1("pcwrite", PCWrite, e_pcw);
    if (e_pcw) chk32("pc_next", PC_next, e_next);
    chk1("if_req", if_req, e_if_req);
    chk1("stall_ifid", stall_ifid, e_stall);
    chk1("flush_ifid", flush_ifid, e_fifid);
    chk1("flush_idex", flush_idex, e_fidex);
    chk1("fetch_timeout", fetch_timeout, e_tmo);

    @(posedge clk);
    e_if_req = 1'b1;
    e_fifid  = take_rd;
    e_fidex  = take_rd || (fetching && hz);
    e_stall  = fetching && !take_rd && (!ack || hz);
    e_tmo    = 1'b0;
`ifdef PC_SEQ_TIMEOUT_EN
    if (m_waiting && !ack) begin
      m_wait_len++;
      if (m_wait_len == MAXW) begin
        e_tmo = 1'b1;
        m_wait_len = 0;
      end
    end
`endif
    if (fetching && !ack && !m_waiting) m_wait_len = 0;
    if (take_rd) begin
      m_pend = 1'b0;
    end else if (rd && !m_boot) begin
      m_pend = 1'b1;
      m_pend_tgt = tgt & ~32'h3;
    end
    if (e_pcw) m_pc = e_next;
    m_waiting = fetching && !ack;
    m_redir   = take_rd;
    m_boot    = 1'b0;
    #1;
  endtask

  initial begin
    model_reset();
    m_pc = 32'hDEAD_BEE0;
    #1;
    do_reset();

    // Boot then three sequential acks: 0, 4, 8, 12.
    step(1, 0, 0, '0);
    chk1("boot_if_req", last_ifreq, 1'b0);
    chk32("boot_pc", last_next, 32'h0);
    step(1, 0, 0, '0);
    chk1("seq_if_req", last_ifreq, 1'b1);
    chk32("seq_pc4", last_next, 32'h4);
    step(1, 0, 0, '0);
    chk32("seq_pc8", last_next, 32'h8);
    step(1, 0, 0, '0);
    chk32("seq_pc12", last_next, 32'hC);

    // Three-cycle fetch wait at 0x100, then advance to 0x104.
    m_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0);
      chk1("wait_pcwrite", last_pcw, 1'b0);
      if (i > 0) chk1("wait_stall", last_stall, 1'b1);
    end
    step(1, 0, 0, '0);
    chk1("wait_end_stall", last_stall, 1'b1);
    chk32("wait_end_pc", last_next, 32'h104);

    // Redirect arrives during WAIT, ack two cycles later.
    step(0, 0, 0, '0);
    step(0, 0, 1, 32'h200);
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    chk1("pend_pcwrite", last_pcw, 1'b1);
    chk32("pend_pc", last_next, 32'h200);
    step(0, 0, 0, '0);
    chk1("redir_flush_ifid", last_fifid, 1'b1);
    chk1("redir_flush_idex", last_fidex, 1'b1);
    chk1("redir_if_req", last_ifreq, 1'b1);

    // Redirect beats a simultaneous load-use hazard.
    step(1, 1, 1, 32'h40);
    chk32("prio_pc", last_next, 32'h40);
    step(0, 0, 0, '0);

    // Misaligned target is forced to a word boundary.
    step(1, 0, 1, 32'h303);
    chk32("align_pc", last_next, 32'h300);
    step(0, 0, 0, '0);

    // Sequential wrap at the top of the address space.
    m_pc = 32'hFFFF_FFFC;
    step(1, 0, 0, '0);
    chk32("wrap_pc", last_next, 32'h0);

    // Load-use hazard holds the PC and bubbles ID/EX.
    step(1, 1, 0, '0);
    chk1("hz_pcwrite", last_pcw, 1'b0);
    step(1, 0, 0, '0);
    chk1("hz_stall", last_stall, 1'b1);
    chk1("hz_flush_idex", last_fidex, 1'b1);
    chk32("hz_resume_pc", last_next, 32'h4);

    // Ack withheld for 20 cycles.
    tmo_seen = 0;
    pulse_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, '0);
      if (last_tmo && pulse_at < 0) pulse_at = i;
    end
    step(1, 0, 0, '0);
    chk32("tmo_pulses", tmo_seen, EXP_PULSES);
`ifdef PC_SEQ_TIMEOUT_EN
    chk32("tmo_position", pulse_at, 32'd16);
`endif

    // Reset mid-WAIT with a redirect pending.
    step(0, 0, 0, '0);
    step(0, 0, 1, 32'h500);
    step(0, 0, 0, '0);
    do_reset();
    step(1, 0, 0, '0);
    chk1("rst_boot_pcwrite", last_pcw, 1'b1);
    chk32("rst_boot_pc", last_next, RV);
    step(1, 0, 0, '0);
    chk32("rst_no_pending", last_next, RV + 32'h4);
    chk1("rst_no_flush", last_fifid, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- INSTR_BYTES, 4, sequential PC increment.
- MAX_WAIT, 15, fetch-wait cycles before timeout (1..255).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- pc_in, in, 32, current PC register value.
- if_ack, in, 1, instruction memory returned data this cycle.
- load_use_hazard, in, 1, ID-stage hazard stall request.
- ex_redirect, in, 1, EX-stage taken branch/jump, 1-cycle pulse.
- ex_target, in, 32, redirect address, valid with ex_redirect.
- if_req, out, 1, instruction fetch request at pc_in.
- PCWrite, out, 1, PC register load enable.
- PC_next, out, 32, value loaded into the PC register.
- stall_ifid, out, 1, hold IF/ID pipeline register.
- flush_ifid, out, 1, bubble IF/ID.
- flush_idex, out, 1, bubble ID/EX.
- fetch_timeout, out, 1, 1-cycle pulse on wait expiry.

Function
REQ-003 FSM states: BOOT, FETCH, WAIT, REDIRECT; all outputs registered except PC_next and PCWrite, which are combinational from state and registered redirect data.
REQ-004 BOOT: PCWrite=1, PC_next=RESET_VECTOR, if_req=0; next state FETCH unconditionally.
REQ-005 FETCH: if_req=1; on if_ack with no hazard and no redirect, PCWrite=1, PC_next=pc_in+INSTR_BYTES (mod 2^32, wraps from 32'hFFFF_FFFC to 0).
REQ-006 FETCH with if_ack=0: PCWrite=0, stall_ifid=1, go to WAIT, wait counter cleared.
REQ-007 WAIT: if_req=1, PCWrite=0, stall_ifid=1, counter +1 per cycle; on if_ack return to FETCH behaviour same cycle (REQ-005).
REQ-008 WAIT counter reaching MAX_WAIT: fetch_timeout=1 for one cycle, counter clears, if_req stays asserted (retry); state stays WAIT.
REQ-009 load_use_hazard=1 (FETCH or WAIT): PCWrite=0, stall_ifid=1, flush_idex=1; no counter effect.
REQ-010 ex_redirect in FETCH with if_ack: PCWrite=1, PC_next=ex_target, flush_ifid=1, flush_idex=1; go to REDIRECT.
REQ-011 ex_redirect while if_ack=0: ex_target latched as pending; fetch is not abandoned; on if_ack, redirect applied as REQ-010, fetched word flushed.
REQ-012 REDIRECT: one cycle, if_req=1, flush_ifid=1; then FETCH.
REQ-013 Priority: redirect (live or pending) > load_use_hazard > sequential advance; a second ex_redirect while pending overwrites the latched target.
REQ-014 ex_target with bits[1:0]!=0 is forced word-aligned (bits cleared).

Reset
REQ-015 rst asserted at any time, including mid-WAIT or pending redirect: state=BOOT, counter=0, pending cleared, all registered outputs 0, within the same cycle.
REQ-016 First rising edge after rst deassertion executes BOOT.

Configuration
REQ-017 Macro PC_SEQ_TIMEOUT_EN: defined -> REQ-008 counter and fetch_timeout implemented; undefined -> no counter, fetch_timeout tied 0, WAIT lasts until if_ack indefinitely.

Structure
REQ-018 Shared package pc_ctrl_pkg holds state enum (BOOT, FETCH, WAIT, REDIRECT), INSTR_BYTES default, alignment mask constant.
REQ-019 One sub-module pc_wait_timer (counter, clear, expiry pulse), instantiated only under PC_SEQ_TIMEOUT_EN.

Verification
REQ-020 Reset then 3 acks with pc_in tracking PC_next -> PC_next sequence 0, 4, 8, 12; if_req=1 from cycle 2.
REQ-021 pc_in=32'h100, if_ack low 3 cycles -> PCWrite=0, stall_ifid=1 for 3 cycles; ack -> PC_next=32'h104.
REQ-022 ex_redirect target 32'h200 during WAIT, ack 2 cycles later -> PC_next=32'h200, flush_ifid=flush_idex=1 that cycle, then REDIRECT.
REQ-023 load_use_hazard and ex_redirect(32'h40) same cycle with ack -> PC_next=32'h40 (redirect wins).
REQ-024 With PC_SEQ_TIMEOUT_EN, MAX_WAIT=15, ack withheld 20 cycles -> single fetch_timeout pulse at wait cycle 15.
REQ-025 rst pulse mid-WAIT with pending redirect -> next PC_next=RESET_VECTOR, pending discarded.
